// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable clock divider with glitch-free reload
//
// Purpose: divides clkin by a runtime-programmable period div_r with a
// programmable high time high_r. New settings are staged in shadow registers
// and take effect only at a period boundary, so the divided clock never
// produces a runt pulse.
//
// Optional feature: define CLK_DIV_STEP_EN to add the single-period step input.
//
// Ports:
//   clkin    in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   run request
//   div_in   in   requested period (clkin cycles)
//   high_in  in   requested high time (clkin cycles)
//   load     in   strobe capturing div_in/high_in
//   step     in   (CLK_DIV_STEP_EN only) run one period from IDLE
//   clk      out  divided clock, registered
//   tick     out  one-cycle pulse at each period start
//   busy     out  validated load pending
//   load_ack out  pulse in the first cycle running with new settings
//   err      out  sticky illegal-load flag
module clk_div_prog #(
   parameter int WIDTH    = 28,
   parameter int DIV_RST  = 2,
   parameter int HIGH_RST = 1
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] high_in,
   input  logic             load,
`ifdef CLK_DIV_STEP_EN
   input  logic             step,
`endif
   output logic             clk,
   output logic             tick,
   output logic             busy,
   output logic             load_ack,
   output logic             err
);

   generate
      if (DIV_RST < 2 || HIGH_RST < 1 || HIGH_RST >= DIV_RST) begin : g_bad_reset_values
         $error("clk_div_prog: reset divisor/high time out of range");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] div_r, div_n;
   logic [WIDTH-1:0] high_r, high_n;
   logic [WIDTH-1:0] sh_div, sh_high;
   logic             xfer;
   logic             go;
   logic             load_ok;
   logic             clk_n, tick_n;

   assign load_ok = load && (div_in >= WIDTH'(2)) && (high_in >= WIDTH'(1))
                    && (high_in < div_in);

`ifdef CLK_DIV_STEP_EN
   // step only matters from IDLE; in RUN the wrap decision looks at en alone,
   // so a stepped period ends at its own wrap unless en has been raised.
   assign go = en | step;
`else
   assign go = en;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = div_r;
      high_n  = high_r;
      xfer    = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            xfer  = busy;
            if (go) state_n = RUN;
         end
         RUN: begin
            if (cnt == div_r - WIDTH'(1)) begin
               cnt_n = '0;
               xfer  = busy;
               if (!en) state_n = IDLE;
            end else begin
               cnt_n = cnt + WIDTH'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (xfer) begin
         div_n  = sh_div;
         high_n = sh_high;
      end
      // Outputs are registered from next-cycle values so they line up with cnt.
      clk_n  = (state_n == RUN) && (cnt_n < high_n);
      tick_n = (state_n == RUN) && (cnt_n == '0);
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         div_r    <= WIDTH'(DIV_RST);
         high_r   <= WIDTH'(HIGH_RST);
         sh_div   <= WIDTH'(DIV_RST);
         sh_high  <= WIDTH'(HIGH_RST);
         clk      <= 1'b0;
         tick     <= 1'b0;
         busy     <= 1'b0;
         load_ack <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_r    <= div_n;
         high_r   <= high_n;
         clk      <= clk_n;
         tick     <= tick_n;
         load_ack <= xfer;
         // A load landing on a transfer edge refills the shadow after the
         // transfer has consumed the old one, keeping busy set.
         if (load_ok) begin
            sh_div  <= div_in;
            sh_high <= high_in;
            busy    <= 1'b1;
         end else if (xfer) begin
            busy    <= 1'b0;
         end
         if (load_ok) begin
            err <= 1'b0;
         end else if (load) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

   localparam int W = 28;

   logic         clkin = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] div_in = '0;
   logic [W-1:0] high_in = '0;
`ifdef CLK_DIV_STEP_EN
   logic         step = 1'b0;
`endif
   logic         clk, tick, busy, load_ack, err;

   int n_cmp = 0;
   int n_bad = 0;

   clk_div_prog #(.WIDTH(W), .DIV_RST(2), .HIGH_RST(1)) dut (
      .clkin    (clkin),
      .rst      (rst),
      .en       (en),
      .div_in   (div_in),
      .high_in  (high_in),
      .load     (load),
`ifdef CLK_DIV_STEP_EN
      .step     (step),
`endif
      .clk      (clk),
      .tick     (tick),
      .busy     (busy),
      .load_ack (load_ack),
      .err      (err)
   );

   always #5 clkin = ~clkin;

   task automatic cyc();
      @(posedge clkin);
      #1;
   endtask

   task automatic set_load(input int d, input int h);
      div_in  = W'(d);
      high_in = W'(h);
      load    = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      load = 1'b0;
      repeat (2) cyc();
      n_cmp++; if (clk !== 1'b0) begin n_bad++; $display("FAIL reset_clk got %b want 0", clk); end
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", tick); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", load_ack); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
      rst = 1'b0;
      repeat (2) cyc();
      n_cmp++; if (clk !== 1'b0 || tick !== 1'b0) begin n_bad++; $display("FAIL idle_out got clk=%b tick=%b want 0 0", clk, tick); end
   endtask

   task automatic test_default();
      logic [0:7] e_ck;
      e_ck = 8'b1010_1010;
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL default_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_ck[i]) begin n_bad++; $display("FAIL default_tick[%0d] got %b want %b", i, tick, e_ck[i]); end
      end
   endtask

   task automatic wait_tick(input string tag);
      for (int k = 0; k < 40 && tick !== 1'b1; k++) cyc();
      n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL %s_wait_tick got %b want 1", tag, tick); end
   endtask

   task automatic test_load_mid();
      logic [0:7] e_ck, e_tk, e_bz, e_ak;
      e_ck = 8'b0110_0011;
      e_tk = 8'b0100_0010;
      e_bz = 8'b1000_0000;
      e_ak = 8'b0100_0000;
      wait_tick("load_mid");
      set_load(5, 2);
      for (int i = 0; i < 8; i++) begin
         cyc();
         load = 1'b0;
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL load_mid_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_tk[i]) begin n_bad++; $display("FAIL load_mid_tick[%0d] got %b want %b", i, tick, e_tk[i]); end
         n_cmp++; if (busy !== e_bz[i]) begin n_bad++; $display("FAIL load_mid_busy[%0d] got %b want %b", i, busy, e_bz[i]); end
         n_cmp++; if (load_ack !== e_ak[i]) begin n_bad++; $display("FAIL load_mid_ack[%0d] got %b want %b", i, load_ack, e_ak[i]); end
      end
   endtask

   task automatic test_illegal();
      logic [0:15] e_ck, e_tk, e_er, e_bz, e_ak;
      e_ck = 16'b1000_1100_0111_0001;
      e_tk = 16'b0000_1000_0100_0001;
      e_er = 16'b1111_1000_0000_0000;
      e_bz = 16'b0000_0111_1000_0000;
      e_ak = 16'b0000_0000_0100_0000;
      wait_tick("illegal");
      set_load(4, 4);
      for (int i = 0; i < 16; i++) begin
         cyc();
         load = 1'b0;
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL illegal_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_tk[i]) begin n_bad++; $display("FAIL illegal_tick[%0d] got %b want %b", i, tick, e_tk[i]); end
         n_cmp++; if (err !== e_er[i]) begin n_bad++; $display("FAIL illegal_err[%0d] got %b want %b", i, err, e_er[i]); end
         n_cmp++; if (busy !== e_bz[i]) begin n_bad++; $display("FAIL illegal_busy[%0d] got %b want %b", i, busy, e_bz[i]); end
         n_cmp++; if (load_ack !== e_ak[i]) begin n_bad++; $display("FAIL illegal_ack[%0d] got %b want %b", i, load_ack, e_ak[i]); end
         if (i == 4) set_load(6, 3);
      end
   endtask

   task automatic test_coincident();
      logic [0:11] e_ck, e_tk, e_bz, e_ak;
      e_ck = 12'b0111_0000_1001;
      e_tk = 12'b0100_0000_1001;
      e_bz = 12'b1111_1111_0000;
      e_ak = 12'b0100_0000_1000;
      wait_tick("coincident");
      repeat (4) cyc();
      set_load(7, 3);
      for (int i = 0; i < 12; i++) begin
         cyc();
         load = 1'b0;
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL coincident_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_tk[i]) begin n_bad++; $display("FAIL coincident_tick[%0d] got %b want %b", i, tick, e_tk[i]); end
         n_cmp++; if (busy !== e_bz[i]) begin n_bad++; $display("FAIL coincident_busy[%0d] got %b want %b", i, busy, e_bz[i]); end
         n_cmp++; if (load_ack !== e_ak[i]) begin n_bad++; $display("FAIL coincident_ack[%0d] got %b want %b", i, load_ack, e_ak[i]); end
         if (i == 0) set_load(3, 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [0:6] e_ck, e_tk, e_bz, e_ak;
      e_ck = 7'b0011_001;
      e_tk = 7'b0010_001;
      e_bz = 7'b1100_000;
      e_ak = 7'b0010_000;
      wait_tick("back_to_back");
      set_load(7, 3);
      for (int i = 0; i < 7; i++) begin
         cyc();
         load = 1'b0;
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL b2b_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_tk[i]) begin n_bad++; $display("FAIL b2b_tick[%0d] got %b want %b", i, tick, e_tk[i]); end
         n_cmp++; if (busy !== e_bz[i]) begin n_bad++; $display("FAIL b2b_busy[%0d] got %b want %b", i, busy, e_bz[i]); end
         n_cmp++; if (load_ack !== e_ak[i]) begin n_bad++; $display("FAIL b2b_ack[%0d] got %b want %b", i, load_ack, e_ak[i]); end
         if (i == 0) set_load(4, 2);
      end
   endtask

   task automatic test_en_drop();
      logic [0:8]  d_ck;
      logic [0:11] r_ck, r_tk;
      d_ck = 9'b1_0000_0000;
      r_ck = 12'b1111_1000_0011;
      r_tk = 12'b1000_0000_0010;
      set_load(10, 5);
      for (int k = 0; k < 40; k++) begin
         cyc();
         load = 1'b0;
         if (load_ack === 1'b1) break;
      end
      n_cmp++; if (load_ack !== 1'b1) begin n_bad++; $display("FAIL en_drop_ack got %b want 1", load_ack); end
      n_cmp++; if (clk !== 1'b1 || tick !== 1'b1) begin n_bad++; $display("FAIL en_drop_start got clk=%b tick=%b want 1 1", clk, tick); end
      repeat (3) cyc();
      en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cyc();
         n_cmp++; if (clk !== d_ck[i]) begin n_bad++; $display("FAIL en_drop_clk[%0d] got %b want %b", i, clk, d_ck[i]); end
         n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL en_drop_tick[%0d] got %b want 0", i, tick); end
      end
      en = 1'b1;
      for (int j = 0; j < 12; j++) begin
         cyc();
         n_cmp++; if (clk !== r_ck[j]) begin n_bad++; $display("FAIL en_resume_clk[%0d] got %b want %b", j, clk, r_ck[j]); end
         n_cmp++; if (tick !== r_tk[j]) begin n_bad++; $display("FAIL en_resume_tick[%0d] got %b want %b", j, tick, r_tk[j]); end
         if (j == 3) en = 1'b0;
         if (j == 7) en = 1'b1;
      end
   endtask

   task automatic test_reset_mid();
      logic [0:3] e_ck;
      e_ck = 4'b1010;
      repeat (4) cyc();
      set_load(3, 1);
      cyc();
      load = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pending got %b want 1", busy); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (clk !== 1'b0 || tick !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out got clk=%b tick=%b want 0 0", clk, tick); end
      n_cmp++; if (busy !== 1'b0 || load_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flags got busy=%b ack=%b err=%b want 0 0 0", busy, load_ack, err); end
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL rst_mid_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_ck[i]) begin n_bad++; $display("FAIL rst_mid_tick[%0d] got %b want %b", i, tick, e_ck[i]); end
         n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack[%0d] got %b want 0", i, load_ack); end
      end
   endtask

`ifdef CLK_DIV_STEP_EN
   task automatic test_step();
      logic [0:7] e_ck;
      int ticks, highs;
      e_ck = 8'b1000_0000;
      ticks = 0;
      highs = 0;
      rst = 1'b1;
      en = 1'b0;
      cyc();
      rst = 1'b0;
      set_load(3, 1);
      cyc();
      load = 1'b0;
      cyc();
      n_cmp++; if (load_ack !== 1'b1 || clk !== 1'b0) begin n_bad++; $display("FAIL step_idle_load got ack=%b clk=%b want 1 0", load_ack, clk); end
      step = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         step = (i == 1);
         n_cmp++; if (clk !== e_ck[i]) begin n_bad++; $display("FAIL step_clk[%0d] got %b want %b", i, clk, e_ck[i]); end
         n_cmp++; if (tick !== e_ck[i]) begin n_bad++; $display("FAIL step_tick[%0d] got %b want %b", i, tick, e_ck[i]); end
         ticks += int'(tick);
         highs += int'(clk);
      end
      n_cmp++; if (ticks != 1 || highs != 1) begin n_bad++; $display("FAIL step_count got ticks=%0d highs=%0d want 1 1", ticks, highs); end
   endtask
`endif

   initial begin
      test_reset();
      test_default();
      test_load_mid();
      test_illegal();
      test_coincident();
      test_back_to_back();
      test_en_drop();
      test_reset_mid();
`ifdef CLK_DIV_STEP_EN
      test_step();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
